// File: rtl/commit_mon_pkg.sv
// Shared types and helpers for the commit monitor: FSM states, datapath widths
// and the writeback signature fold.
package commit_mon_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        HALTED  = 2'd1,
        TIMEOUT = 2'd2
    } mon_state_t;

    // Rotate-left-by-one, then mix in the written value and its destination index.
    function automatic logic [XLEN-1:0] sig_fold(
        input logic [XLEN-1:0]   sig,
        input logic [XLEN-1:0]   data,
        input logic [REG_AW-1:0] rd
    );
        return {sig[XLEN-2:0], sig[XLEN-1]} ^ data ^ {{(XLEN-REG_AW){1'b0}}, rd};
    endfunction

endpackage

// File: rtl/commit_mon_shadow_rf.sv
// Shadow copy of the architectural register file, rebuilt from committed
// writebacks. One write port, one combinational read port, entry 0 reads 0.
module commit_mon_shadow_rf
    import commit_mon_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [REG_AW-1:0] raddr,
    output logic [XLEN-1:0]   rdata
);

    logic [XLEN-1:0] mem [1 << REG_AW];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < (1 << REG_AW); i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = (raddr == '0) ? '0 : mem[raddr];

endmodule

// File: rtl/commit_monitor.sv
// Observes writeback/PC traffic, builds a commit signature and detects program end
// (branch-to-self halt or cycle budget). COMMIT_MON_SHADOW_EN adds a shadow register file.
module commit_monitor
    import commit_mon_pkg::*;
#(
    parameter int STALL_LIMIT = 4,
    parameter int MAX_CYCLES  = 100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   pc,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_reg,
    input  logic [XLEN-1:0]   wb_data,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic              done,
    output logic              timeout,
    output logic [XLEN-1:0]   cycle_count,
    output logic [XLEN-1:0]   wb_count,
    output logic [XLEN-1:0]   signature,
    output logic [XLEN-1:0]   halt_pc,
    output logic [XLEN-1:0]   dbg_rdata
);

    localparam logic [7:0]      REP_LIMIT  = 8'(STALL_LIMIT);
    localparam logic [XLEN-1:0] CYC_LAST   = XLEN'(MAX_CYCLES - 1);

    mon_state_t      state, state_next;
    logic [XLEN-1:0] prev_pc;
    logic            prev_vld;
    logic [7:0]      rep_cnt, rep_next;
    logic            halt_hit, budget_hit, running, commit;

    // The very first sample after reset has nothing to compare against.
    always_comb begin
        rep_next = '0;
        if (prev_vld && (pc == prev_pc)) begin
            rep_next = (rep_cnt >= REP_LIMIT) ? REP_LIMIT : rep_cnt + 8'd1;
        end
    end

    assign halt_hit   = (rep_next == REP_LIMIT);
    assign budget_hit = (cycle_count == CYC_LAST);
    assign commit     = running && wb_en && (wb_reg != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Halt takes priority over timeout when both land on the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (halt_hit) begin
                    state_next = HALTED;
                end else if (budget_hit) begin
                    state_next = TIMEOUT;
                end
            end
            default: state_next = state;
        endcase
    end

    always_comb begin
        running = (state == RUN);
        done    = (state == HALTED);
        timeout = (state == TIMEOUT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_pc     <= '0;
            prev_vld    <= 1'b0;
            rep_cnt     <= '0;
            cycle_count <= '0;
            wb_count    <= '0;
            signature   <= '0;
            halt_pc     <= '0;
        end else begin
            prev_pc  <= pc;
            prev_vld <= 1'b1;
            rep_cnt  <= rep_next;
            if (running) begin
                cycle_count <= cycle_count + 1'b1;
                if (halt_hit) begin
                    halt_pc <= pc;
                end
            end
            if (commit) begin
                if (wb_count != '1) begin
                    wb_count <= wb_count + 1'b1;
                end
                signature <= sig_fold(signature, wb_data, wb_reg);
            end
        end
    end

`ifdef COMMIT_MON_SHADOW_EN
    commit_mon_shadow_rf u_shadow (
        .clk   (clk),
        .reset (reset),
        .we    (commit),
        .waddr (wb_reg),
        .wdata (wb_data),
        .raddr (dbg_addr),
        .rdata (dbg_rdata)
    );
`else
    logic unused_dbg_addr;
    assign unused_dbg_addr = ^dbg_addr;
    assign dbg_rdata       = '0;
`endif

endmodule

// File: tb/tb_commit_monitor.sv
// Self-checking bench for commit_monitor: directed scenarios plus randomized traffic
// against a history-based reference model; honours COMMIT_MON_SHADOW_EN.
module tb_commit_monitor;

    localparam int SL = 4;
    localparam int MC = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc, wb_data;
    logic        wb_en;
    logic [4:0]  wb_reg, dbg_addr;
    logic        done, timeout;
    logic [31:0] cycle_count, wb_count, signature, halt_pc, dbg_rdata;

    commit_monitor #(.STALL_LIMIT(SL), .MAX_CYCLES(MC)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .wb_en       (wb_en),
        .wb_reg      (wb_reg),
        .wb_data     (wb_data),
        .dbg_addr    (dbg_addr),
        .done        (done),
        .timeout     (timeout),
        .cycle_count (cycle_count),
        .wb_count    (wb_count),
        .signature   (signature),
        .halt_pc     (halt_pc),
        .dbg_rdata   (dbg_rdata)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit          m_done, m_to;
    logic [31:0] m_cyc, m_wbc, m_sig, m_hpc;
    logic [31:0] m_shadow [32];
    logic [31:0] hist [$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_done = 0; m_to = 0;
        m_cyc = 0; m_wbc = 0; m_sig = 0; m_hpc = 0;
        for (int i = 0; i < 32; i++) m_shadow[i] = 0;
        hist.delete();
    endtask

    // Halt = the last SL+1 PC samples since reset are all identical.
    task automatic model_step();
        bit halt;
        if (reset) begin
            model_clear();
            return;
        end
        hist.push_back(pc);
        if (hist.size() > SL + 1) void'(hist.pop_front());
        halt = (hist.size() == SL + 1);
        for (int i = 1; i < hist.size(); i++)
            if (hist[i] != hist[0]) halt = 0;
        if (!m_done && !m_to) begin
            if (wb_en && wb_reg != 0) begin
                if (m_wbc != 32'hFFFF_FFFF) m_wbc = m_wbc + 1;
                m_sig = ((m_sig << 1) | (m_sig >> 31)) ^ wb_data ^ 32'(wb_reg);
                m_shadow[wb_reg] = wb_data;
            end
            if (halt) begin
                m_done = 1;
                m_hpc  = pc;
            end else if (m_cyc == MC - 1) begin
                m_to = 1;
            end
            m_cyc = m_cyc + 1;
        end
    endtask

    function automatic logic [31:0] exp_dbg();
`ifdef COMMIT_MON_SHADOW_EN
        return m_shadow[dbg_addr];
`else
        return 32'h0;
`endif
    endfunction

    task automatic check_all(input string tag);
        check_eq({tag, ".done"},    {31'b0, done},    {31'b0, m_done});
        check_eq({tag, ".timeout"}, {31'b0, timeout}, {31'b0, m_to});
        check_eq({tag, ".cycles"},  cycle_count,      m_cyc);
        check_eq({tag, ".wbcount"}, wb_count,         m_wbc);
        check_eq({tag, ".sig"},     signature,        m_sig);
        check_eq({tag, ".haltpc"},  halt_pc,          m_hpc);
        check_eq({tag, ".dbg"},     dbg_rdata,        exp_dbg());
    endtask

    task automatic cyc(input string tag, input logic r, input logic [31:0] p, input logic we,
                       input logic [4:0] rd, input logic [31:0] d, input logic [4:0] da);
        reset = r; pc = p; wb_en = we; wb_reg = rd; wb_data = d; dbg_addr = da;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        logic [31:0] rp;
        model_clear();

        // Reset state
        cyc("rst", 1, 32'h0, 0, 0, 0, 0);
        cyc("rst", 1, 32'h0, 1, 5, 32'h1234, 5);
        check_eq("rst_sig", signature, 32'h0);
        check_eq("rst_done", {31'b0, done}, 32'h0);

        // Basic signature folding
        cyc("wb8", 0, 32'h00, 1, 8, 32'h5, 8);
        check_eq("sig_after_r8", signature, 32'h0000_000D);
        cyc("wb9", 0, 32'h04, 1, 9, 32'h1, 9);
        check_eq("sig_after_r9", signature, 32'h0000_0012);
        check_eq("wbcount_2", wb_count, 32'd2);

        // Writes to $0 are ignored
        cyc("wb0", 0, 32'h08, 1, 0, 32'hFFFF_FFFF, 0);
        check_eq("sig_r0_unch", signature, 32'h0000_0012);
        check_eq("wbc_r0_unch", wb_count, 32'd2);
        check_eq("dbg_r0", dbg_rdata, 32'h0);

        // Shadow readback of reg 31
        cyc("wb31", 0, 32'h0C, 1, 31, 32'hDEAD_BEEF, 31);
`ifdef COMMIT_MON_SHADOW_EN
        check_eq("dbg_r31", dbg_rdata, 32'hDEAD_BEEF);
`else
        check_eq("dbg_r31", dbg_rdata, 32'h0);
`endif

        // Branch-to-self halt
        cyc("hrst", 1, 32'h0, 0, 0, 0, 0);
        cyc("h0", 0, 32'h00, 0, 0, 0, 0);
        cyc("h4", 0, 32'h04, 0, 0, 0, 0);
        cyc("h8", 0, 32'h08, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc("hC", 0, 32'h0C, 0, 0, 0, 0);
        check_eq("halt_early", {31'b0, done}, 32'h0);
        cyc("hC5", 0, 32'h0C, 0, 0, 0, 0);
        check_eq("halt_done", {31'b0, done}, 32'h1);
        check_eq("halt_pc", halt_pc, 32'h0C);
        cyc("hwb", 0, 32'h0C, 1, 3, 32'h77, 3);
        check_eq("halt_wb_ign", wb_count, 32'h0);
        check_eq("halt_cyc_frz", cycle_count, 32'd8);

        // Cycle budget timeout
        cyc("trst", 1, 32'h0, 0, 0, 0, 0);
        for (int i = 0; i < MC - 1; i++) cyc("trun", 0, 32'(i * 4), 0, 0, 0, 0);
        check_eq("to_early", {31'b0, timeout}, 32'h0);
        cyc("tlast", 0, 32'(396), 0, 0, 0, 0);
        check_eq("to_hit", {31'b0, timeout}, 32'h1);
        check_eq("to_cycles", cycle_count, 32'd100);
        for (int i = 0; i < 3; i++) cyc("tpost", 0, 32'(400 + i * 4), 1, 2, 32'h9, 2);
        check_eq("to_cycles_frz", cycle_count, 32'd100);
        check_eq("to_nodone", {31'b0, done}, 32'h0);

        // Halt and timeout on the same cycle
        cyc("brst", 1, 32'h0, 0, 0, 0, 0);
        for (int i = 0; i < MC - SL - 1; i++) cyc("brun", 0, 32'(i * 4), 0, 0, 0, 0);
        for (int i = 0; i < SL + 1; i++) cyc("bspin", 0, 32'h1000, 0, 0, 0, 0);
        check_eq("both_done", {31'b0, done}, 32'h1);
        check_eq("both_noto", {31'b0, timeout}, 32'h0);
        check_eq("both_cycles", cycle_count, 32'd100);
        cyc("brst2", 1, 32'h0, 0, 0, 0, 0);
        check_eq("brst_done", {31'b0, done}, 32'h0);
        check_eq("brst_haltpc", halt_pc, 32'h0);
        check_eq("brst_cycles", cycle_count, 32'h0);

        // Randomized traffic
        rp = 32'h0;
        for (int i = 0; i < 600; i++) begin
            logic r;
            r = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 1) == 0) rp = {$urandom_range(0, 15), 2'b00};
            cyc("rnd", r, rp, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                $urandom, 5'($urandom_range(0, 31)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
